// File: rtl/vector_stream_scheduler.sv
// vector_stream_scheduler: round-robin vector arbiter that serialises granted vectors into cell beats.
// streamOut layout, MSB to LSB: {isResult, wIndex, isLast, isFirst, isValid, data}.
module vector_stream_scheduler #(
  parameter int bitwidth = 8,
  parameter int inputVectorSize = 3,
  parameter int NUM_REQ = 2,
  parameter int GAP = 1,
  localparam int IW = inputVectorSize > 1 ? $clog2(inputVectorSize) : 1,
  localparam int LW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
  localparam int VW = inputVectorSize * bitwidth
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*VW-1:0]       req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [bitwidth+IW+3:0]      streamOut,
  output logic                        busy,
  output logic [15:0]                 vec_count
);
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP} state_t;
  state_t state, next;
  logic [LW-1:0] last_grant, win;
  logic [IW-1:0] k, nk;
  logic [3:0] gcnt;
  logic [VW-1:0] vec, slice;
  logic [bitwidth-1:0] elem;
  logic grant, found, last_beat, gap_done, nvalid;
  always_comb begin
    win = last_grant;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && req_valid[(int'(last_grant) + i) % NUM_REQ]) begin
        found = 1'b1;
        win = LW'((int'(last_grant) + i) % NUM_REQ);
      end
    end
    grant = state == S_IDLE && enable && found;
    last_beat = k == IW'(inputVectorSize - 1);
    gap_done = gcnt == 4'(GAP - 1);
    next = state == S_IDLE   ? (grant ? S_STREAM : S_IDLE) :
           state == S_STREAM ? (last_beat ? (GAP > 0 ? S_GAP : S_IDLE) : S_STREAM) :
                               (gap_done ? S_IDLE : S_GAP);
    slice = req_data[int'(win) * VW +: VW];
    nvalid = grant || (state == S_STREAM && !last_beat);
    nk = grant ? '0 : k + 1'b1;
    // Element 0 goes straight out on the grant edge; the rest come from the shifted copy.
    elem = grant ? slice[bitwidth-1:0] : vec[bitwidth-1:0];
  end
  assign req_ready = (grant && !reset) ? NUM_REQ'(1) << win : '0;
  assign busy = state != S_IDLE;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else state <= next;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      streamOut <= '0;
      k <= '0;
      gcnt <= '0;
      vec <= '0;
      last_grant <= LW'(NUM_REQ - 1);
      vec_count <= '0;
    end else begin
      streamOut <= nvalid ? {1'b0, nk, nk == IW'(inputVectorSize - 1), nk == '0, 1'b1, elem} : '0;
      if (nvalid) k <= nk;
      gcnt <= state == S_GAP ? gcnt + 1'b1 : '0;
      if (grant) begin
        vec <= slice >> bitwidth;
        last_grant <= win;
      end else if (state == S_STREAM) vec <= vec >> bitwidth;
      if (state == S_STREAM && last_beat) vec_count <= vec_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_vector_stream_scheduler.sv
// tb_vector_stream_scheduler: directed stimulus with a queue scoreboard checked by per-DUT beat monitors.
module tb_vector_stream_scheduler;
  logic clock = 0, reset = 0, enable = 0, b_enable = 1;
  always #5 clock = ~clock;
  logic [1:0] a_valid = 0, a_ready, b_valid = 0, b_ready;
  logic [47:0] a_data = 0;
  logic [15:0] b_data = 0;
  logic [13:0] a_so;
  logic [12:0] b_so;
  logic a_busy, b_busy;
  logic [15:0] a_vc, b_vc;
  int compared = 0, mismatched = 0, cyc = 0, b_idle = 0, g_prev = 0;
  bit b_seen = 0;
  logic [13:0] qa[$];
  logic [12:0] qb[$];
  logic [23:0] q0 = {8'd6, 8'd5, 8'd4};
  logic [23:0] q1 = {8'd4, 8'd3, 8'd2};

  vector_stream_scheduler #(.bitwidth(8), .inputVectorSize(3), .NUM_REQ(2), .GAP(1)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .req_valid(a_valid), .req_data(a_data),
    .req_ready(a_ready), .streamOut(a_so), .busy(a_busy), .vec_count(a_vc));
  vector_stream_scheduler #(.bitwidth(8), .inputVectorSize(1), .NUM_REQ(2), .GAP(0)) dut_b (
    .clock(clock), .reset(reset), .enable(b_enable), .req_valid(b_valid), .req_data(b_data),
    .req_ready(b_ready), .streamOut(b_so), .busy(b_busy), .vec_count(b_vc));

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [13:0] beat_a(input logic [7:0] d, input int k);
    return {1'b0, 2'(k), k == 2, k == 0, 1'b1, d};
  endfunction

  task automatic push_a(input logic [23:0] v);
    for (int k = 0; k < 3; k++) qa.push_back(beat_a(v[k*8 +: 8], k));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    a_valid = 0;
    tick();
    reset = 1;
    tick();
    #1;
    check("reset_state", {a_ready, a_busy, a_vc, a_so}, 0);
    reset = 0;
    tick();
  endtask

  task automatic wait_grant(input logic [1:0] exp, input string name);
    int n = 0;
    while (a_ready == 0 && n < 20) begin
      tick();
      #1;
      n++;
    end
    check(name, a_ready, exp);
  endtask

  always @(negedge clock) begin
    if (!reset && a_so[8]) begin
      if (qa.size() == 0) check("a_beat_unexpected", a_so, 0);
      else check("a_beat", a_so, qa.pop_front());
    end
  end

  always @(negedge clock) begin
    if (reset) b_seen = 0;
    else if (b_so[8]) begin
      if (qb.size() == 0) check("b_beat_unexpected", b_so, 0);
      else check("b_beat", b_so, qb.pop_front());
      if (b_seen) check("b_gap", b_idle, 1);
      b_seen = 1;
      b_idle = 0;
    end else b_idle++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    enable = 1;
    // single vector
    do_reset();
    a_data = {q1, q0};
    a_valid = 2'b01;
    #1 check("single_grant", a_ready, 2'b01);
    push_a(q0);
    tick();
    a_valid = 0;
    #1 check("single_busy", {a_ready, a_busy}, 3'b001);
    repeat (3) tick();
    #1 check("single_gap", {a_busy, a_vc, a_so}, {1'b1, 16'd1, 14'd0});
    tick();
    #1 check("single_idle", {a_busy, a_so}, 0);
    // round-robin
    do_reset();
    a_valid = 2'b11;
    #1 wait_grant(2'b01, "rr_grant0");
    g_prev = cyc;
    push_a(q0);
    tick();
    wait_grant(2'b10, "rr_grant1");
    check("rr_period1", cyc - g_prev, 5);
    g_prev = cyc;
    push_a(q1);
    tick();
    wait_grant(2'b01, "rr_grant2");
    check("rr_period2", cyc - g_prev, 5);
    push_a(q0);
    tick();
    a_valid = 0;
    repeat (3) tick();
    #1 check("rr_count", {a_vc, a_so}, {16'd3, 14'd0});
    // enable gating
    do_reset();
    enable = 0;
    a_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 check("en_off", {a_ready, a_busy, a_so}, 0);
      tick();
    end
    enable = 1;
    #1 check("en_grant", a_ready, 2'b01);
    push_a(q0);
    tick();
    tick();
    enable = 0;
    tick();
    #1 check("en_last_beat", a_so, beat_a(8'd6, 2));
    for (int i = 0; i < 6; i++) begin
      tick();
      #1 check("en_no_grant", a_ready, 0);
    end
    check("en_done", {a_busy, a_vc}, {1'b0, 16'd1});
    // reset mid-vector
    do_reset();
    enable = 1;
    a_valid = 2'b11;
    #1 check("rst_grant", a_ready, 2'b01);
    push_a(q0);
    tick();
    tick();
    #2 reset = 1;
    #1 check("rst_async", {a_so[8], a_busy, a_vc}, 0);
    qa.delete();
    tick();
    reset = 0;
    #1 check("rst_restart_grant", a_ready, 2'b01);
    push_a(q0);
    tick();
    a_valid = 0;
    repeat (5) tick();
    // data hold
    a_valid = 2'b01;
    #1 check("hold_grant", a_ready, 2'b01);
    push_a(q0);
    tick();
    a_data[23:0] = {8'd9, 8'd9, 8'd9};
    a_valid = 0;
    repeat (5) tick();
    // GAP=0, inputVectorSize=1 corner
    b_data[7:0] = 8'd7;
    b_valid = 2'b01;
    for (int i = 0; i < 4; i++) qb.push_back({1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd7});
    for (int i = 0; i < 8; i++) begin
      #1 check("b_ready", b_ready, (i % 2 == 0) ? 2'b01 : 2'b00);
      tick();
    end
    b_valid = 0;
    #1 check("b_count", b_vc, 16'd4);
    repeat (4) tick();
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
